// File: rtl/rat_io_pkg.sv
// Shared port map and register bit positions for the RAT I/O responder.
package rat_io_pkg;

  localparam logic [7:0] PORT_SWITCHES     = 8'h20;
  localparam logic [7:0] PORT_BUTTONS      = 8'h24;
  localparam logic [7:0] PORT_LEDS         = 8'h40;
  localparam logic [7:0] PORT_TMR_RELOAD   = 8'h30;
  localparam logic [7:0] PORT_TMR_PRESCALE = 8'h31;
  localparam logic [7:0] PORT_TMR_CTRL     = 8'h32;
  localparam logic [7:0] PORT_INT_STATUS   = 8'h33;
  localparam logic [7:0] PORT_TMR_COUNT    = 8'h34;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IE_BIT     = 1;
  localparam int STATUS_PEND_BIT = 0;

  // A write lands only when the strobe is up and the address matches.
  function automatic logic port_hit(input logic strb, input logic [7:0] id,
                                    input logic [7:0] target);
    return strb && (id == target);
  endfunction

endpackage

// File: rtl/rat_io_responder_if.sv
// MCU-side I/O bus between the RAT core (master) and the I/O responder (slave).
interface rat_io_responder_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INTR;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input IN_PORT, INTR);
  modport slave  (input PORT_ID, OUT_PORT, IO_STRB, output IN_PORT, INTR);
endinterface

// File: rtl/rat_io_timer.sv
// Prescaled down-counter with reload and sticky pending flag.
module rat_io_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] prescale,
  input  logic [7:0] reload,
  input  logic [7:0] wr_data,
  input  logic       reload_wr,
  input  logic       clear_pend,
  output logic [7:0] count,
  output logic       pend
);
  logic [7:0] psc;
  logic       tick;
  logic       expire;

  assign tick   = en && (psc == prescale);
  // A reload write replaces the count, so a coincident expiry never happens.
  assign expire = tick && (count == 8'd0) && !reload_wr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      psc   <= 8'd0;
      count <= 8'd0;
      pend  <= 1'b0;
    end else begin
      if (reload_wr) begin
        psc   <= 8'd0;
        count <= wr_data;
      end else if (en) begin
        psc <= tick ? 8'd0 : psc + 8'd1;
        if (tick) count <= (count == 8'd0) ? reload : count - 8'd1;
      end
      if (expire) pend <= 1'b1;
      else if (clear_pend) pend <= 1'b0;
    end
  end
endmodule

// File: rtl/rat_io_responder.sv
// RAT MCU I/O responder: synchronized switches/buttons, LED register, optional
// interval timer with interrupt (enabled by defining RAT_IO_TIMER_EN).
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  rat_io_responder_if.slave        bus,
  input  logic [7:0]               SWITCHES,
  input  logic [3:0]               BUTTONS,
  output logic [7:0]               LEDS
);
  logic [SYNC_STAGES-1:0][7:0] sw_sync;
  logic [SYNC_STAGES-1:0][3:0] btn_sync;
  logic [7:0]                  led_reg;
  logic [7:0]                  rd_data;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sw_sync  <= '0;
      btn_sync <= '0;
      led_reg  <= 8'd0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], SWITCHES};
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], BUTTONS};
      if (port_hit(bus.IO_STRB, bus.PORT_ID, PORT_LEDS)) led_reg <= bus.OUT_PORT;
    end
  end

  assign LEDS = led_reg;

`ifdef RAT_IO_TIMER_EN
  logic [7:0] tmr_reload;
  logic [7:0] tmr_prescale;
  logic [1:0] tmr_ctrl;
  logic [7:0] tmr_count;
  logic       pend;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tmr_reload   <= 8'd0;
      tmr_prescale <= 8'd0;
      tmr_ctrl     <= 2'd0;
    end else begin
      if (port_hit(bus.IO_STRB, bus.PORT_ID, PORT_TMR_RELOAD)) tmr_reload <= bus.OUT_PORT;
      if (port_hit(bus.IO_STRB, bus.PORT_ID, PORT_TMR_PRESCALE)) tmr_prescale <= bus.OUT_PORT;
      if (port_hit(bus.IO_STRB, bus.PORT_ID, PORT_TMR_CTRL))
        tmr_ctrl <= {bus.OUT_PORT[CTRL_IE_BIT], bus.OUT_PORT[CTRL_EN_BIT]};
    end
  end

  rat_io_timer u_timer (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .en        (tmr_ctrl[CTRL_EN_BIT]),
    .prescale  (tmr_prescale),
    .reload    (tmr_reload),
    .wr_data   (bus.OUT_PORT),
    .reload_wr (port_hit(bus.IO_STRB, bus.PORT_ID, PORT_TMR_RELOAD)),
    .clear_pend(port_hit(bus.IO_STRB, bus.PORT_ID, PORT_INT_STATUS)
                && bus.OUT_PORT[STATUS_PEND_BIT]),
    .count     (tmr_count),
    .pend      (pend)
  );

  assign bus.INTR = pend & tmr_ctrl[CTRL_IE_BIT];
`else
  assign bus.INTR = 1'b0;
`endif

  // Zero-latency read mux: the MCU samples IN_PORT in the same execute cycle.
  always_comb begin
    rd_data = 8'd0;
    case (bus.PORT_ID)
      PORT_SWITCHES:     rd_data = sw_sync[SYNC_STAGES-1];
      PORT_BUTTONS:      rd_data = {4'b0000, btn_sync[SYNC_STAGES-1]};
      PORT_LEDS:         rd_data = led_reg;
`ifdef RAT_IO_TIMER_EN
      PORT_TMR_RELOAD:   rd_data = tmr_reload;
      PORT_TMR_PRESCALE: rd_data = tmr_prescale;
      PORT_TMR_CTRL:     rd_data = {6'd0, tmr_ctrl};
      PORT_INT_STATUS:   rd_data = {7'd0, pend};
      PORT_TMR_COUNT:    rd_data = tmr_count;
`endif
      default:           rd_data = 8'd0;
    endcase
  end

  assign bus.IN_PORT = rd_data;
endmodule

// File: tb/tb_rat_io_responder.sv
// Directed self-checking bench for rat_io_responder; timer scenarios are
// exercised when RAT_IO_TIMER_EN is defined, the disabled build otherwise.
module tb_rat_io_responder;
  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] SWITCHES;
  logic [3:0] BUTTONS;
  logic [7:0] LEDS;
  int         checks = 0;
  int         passes = 0;

  rat_io_responder_if bus ();

  rat_io_responder #(.SYNC_STAGES(2)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave),
    .SWITCHES(SWITCHES),
    .BUTTONS (BUTTONS),
    .LEDS    (LEDS)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] id, input logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    tick(1);
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic read_port(input logic [7:0] id, output logic [7:0] data);
    bus.PORT_ID = id;
    #1;
    data = bus.IN_PORT;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    RESET_N      = 1'b0;
    SWITCHES     = 8'hA5;
    BUTTONS      = 4'hA;
    bus.PORT_ID  = 8'h40;
    bus.OUT_PORT = 8'hFF;
    bus.IO_STRB  = 1'b1;
    tick(3);
    bus.IO_STRB = 1'b0;
    checks++; if (LEDS !== 8'h00) $display("[TB] FAIL reset_leds: got %h expected 00", LEDS); else passes++;
    checks++; if (bus.INTR !== 1'b0) $display("[TB] FAIL reset_intr: got %b expected 0", bus.INTR); else passes++;
    read_port(8'h20, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL reset_sw: got %h expected 00", rd); else passes++;
    for (int i = 0; i < 5; i++) begin
      read_port(8'h30 + 8'(i), rd);
      checks++; if (rd !== 8'h00) $display("[TB] FAIL reset_tmr_id%0d: got %h expected 00", i, rd); else passes++;
    end
    bus.PORT_ID = 8'h20;
    RESET_N     = 1'b1;
    tick(1);
    read_port(8'h20, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL sync_stage1: got %h expected 00", rd); else passes++;
    tick(1);
    read_port(8'h20, rd);
    checks++; if (rd !== 8'hA5) $display("[TB] FAIL sync_stage2: got %h expected a5", rd); else passes++;
    read_port(8'h55, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL unmapped_55: got %h expected 00", rd); else passes++;
    read_port(8'h24, rd);
    checks++; if (rd !== 8'h0A) $display("[TB] FAIL buttons: got %h expected 0a", rd); else passes++;
  endtask

  task automatic test_sync_latency();
    logic [7:0] rd;
    SWITCHES = 8'h3C;
    tick(1);
    read_port(8'h20, rd);
    checks++; if (rd !== 8'hA5) $display("[TB] FAIL sw_change_1: got %h expected a5", rd); else passes++;
    tick(1);
    read_port(8'h20, rd);
    checks++; if (rd !== 8'h3C) $display("[TB] FAIL sw_change_2: got %h expected 3c", rd); else passes++;
  endtask

  task automatic test_leds();
    logic [7:0] rd;
    bus_write(8'h40, 8'h3C);
    checks++; if (LEDS !== 8'h3C) $display("[TB] FAIL led_write: got %h expected 3c", LEDS); else passes++;
    read_port(8'h40, rd);
    checks++; if (rd !== 8'h3C) $display("[TB] FAIL led_read: got %h expected 3c", rd); else passes++;
    bus.PORT_ID  = 8'h40;
    bus.OUT_PORT = 8'h81;
    bus.IO_STRB  = 1'b0;
    tick(1);
    checks++; if (LEDS !== 8'h3C) $display("[TB] FAIL led_no_strobe: got %h expected 3c", LEDS); else passes++;
    bus_write(8'h41, 8'h81);
    checks++; if (LEDS !== 8'h3C) $display("[TB] FAIL led_wrong_id: got %h expected 3c", LEDS); else passes++;
    read_port(8'h41, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL unmapped_41: got %h expected 00", rd); else passes++;
  endtask

`ifdef RAT_IO_TIMER_EN
  task automatic test_timer_period();
    logic [7:0] rd;
    bus_write(8'h30, 8'h03);
    bus_write(8'h31, 8'h01);
    bus_write(8'h32, 8'h03);
    tick(7);
    checks++; if (bus.INTR !== 1'b0) $display("[TB] FAIL intr_early: got %b expected 0", bus.INTR); else passes++;
    tick(1);
    checks++; if (bus.INTR !== 1'b1) $display("[TB] FAIL intr_rise8: got %b expected 1", bus.INTR); else passes++;
    read_port(8'h34, rd);
    checks++; if (rd !== 8'h03) $display("[TB] FAIL count_reload: got %h expected 03", rd); else passes++;
    bus_write(8'h33, 8'h01);
    checks++; if (bus.INTR !== 1'b0) $display("[TB] FAIL intr_cleared: got %b expected 0", bus.INTR); else passes++;
    read_port(8'h33, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL pend_cleared: got %h expected 00", rd); else passes++;
    tick(6);
    checks++; if (bus.INTR !== 1'b0) $display("[TB] FAIL intr_early2: got %b expected 0", bus.INTR); else passes++;
    tick(1);
    checks++; if (bus.INTR !== 1'b1) $display("[TB] FAIL intr_rise16: got %b expected 1", bus.INTR); else passes++;
  endtask

  task automatic test_ie_and_reset();
    logic [7:0] rd;
    bus_write(8'h32, 8'h01);
    checks++; if (bus.INTR !== 1'b0) $display("[TB] FAIL ie_off_intr: got %b expected 0", bus.INTR); else passes++;
    read_port(8'h33, rd);
    checks++; if (rd !== 8'h01) $display("[TB] FAIL ie_off_pend: got %h expected 01", rd); else passes++;
    bus_write(8'h33, 8'h01);
    tick(8);
    checks++; if (bus.INTR !== 1'b0) $display("[TB] FAIL ie_off_expiry_intr: got %b expected 0", bus.INTR); else passes++;
    read_port(8'h33, rd);
    checks++; if (rd !== 8'h01) $display("[TB] FAIL ie_off_expiry_pend: got %h expected 01", rd); else passes++;
    read_port(8'h34, rd);
    checks++; if (rd !== 8'h02) $display("[TB] FAIL mid_count: got %h expected 02", rd); else passes++;
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
    read_port(8'h34, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL rst_count: got %h expected 00", rd); else passes++;
    read_port(8'h33, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL rst_status: got %h expected 00", rd); else passes++;
    read_port(8'h40, rd);
    checks++; if (rd !== 8'h00) $display("[TB] FAIL rst_leds: got %h expected 00", rd); else passes++;
  endtask

  task automatic test_coincident_clear();
    logic [7:0] rd;
    bus_write(8'h30, 8'h00);
    bus_write(8'h31, 8'h00);
    bus_write(8'h32, 8'h03);
    tick(1);
    checks++; if (bus.INTR !== 1'b1) $display("[TB] FAIL fast_expiry: got %b expected 1", bus.INTR); else passes++;
    bus_write(8'h33, 8'h01);
    checks++; if (bus.INTR !== 1'b1) $display("[TB] FAIL set_wins_intr: got %b expected 1", bus.INTR); else passes++;
    read_port(8'h33, rd);
    checks++; if (rd !== 8'h01) $display("[TB] FAIL set_wins_pend: got %h expected 01", rd); else passes++;
    bus_write(8'h30, 8'h05);
    read_port(8'h34, rd);
    checks++; if (rd !== 8'h05) $display("[TB] FAIL reload_wins: got %h expected 05", rd); else passes++;
    tick(1);
    read_port(8'h34, rd);
    checks++; if (rd !== 8'h04) $display("[TB] FAIL count_dec: got %h expected 04", rd); else passes++;
    bus_write(8'h32, 8'h02);
    tick(3);
    read_port(8'h34, rd);
    checks++; if (rd !== 8'h03) $display("[TB] FAIL en_freeze: got %h expected 03", rd); else passes++;
    bus_write(8'h32, 8'hFF);
    read_port(8'h32, rd);
    checks++; if (rd !== 8'h03) $display("[TB] FAIL ctrl_mask: got %h expected 03", rd); else passes++;
  endtask
`else
  task automatic test_no_timer();
    logic [7:0] rd;
    logic       intr_seen;
    bus_write(8'h30, 8'hFF);
    bus_write(8'h31, 8'hFF);
    bus_write(8'h32, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      read_port(8'h30 + 8'(i), rd);
      checks++; if (rd !== 8'h00) $display("[TB] FAIL notmr_id%0d: got %h expected 00", i, rd); else passes++;
    end
    intr_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (bus.INTR !== 1'b0) intr_seen = 1'b1;
    end
    checks++; if (intr_seen !== 1'b0) $display("[TB] FAIL notmr_intr: got %b expected 0", intr_seen); else passes++;
  endtask
`endif

  initial begin
    RESET_N      = 1'b0;
    SWITCHES     = 8'h00;
    BUTTONS      = 4'h0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    test_reset();
    test_sync_latency();
    test_leds();
`ifdef RAT_IO_TIMER_EN
    test_timer_period();
    test_ie_and_reset();
    test_coincident_clear();
`else
    test_no_timer();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rat_io_responder.md
RAT_IO_RESPONDER -- requirements
Module: rat_io_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flop stages on SWITCHES/BUTTONS synchronizers (legal 2..4).
REQ-002 SHALL have CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have RESET_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have PORT_ID  input  8  MCU port address.
REQ-005 SHALL have OUT_PORT  input  8  MCU write data.
REQ-006 SHALL have IO_STRB  input  1  MCU write strobe, one-cycle pulse per OUT instruction.
REQ-007 SHALL have IN_PORT  output  8  read data to MCU.
REQ-008 SHALL have INTR  output  1  level interrupt request to MCU.
REQ-009 SHALL have SWITCHES  input  8  and BUTTONS  input  4  asynchronous board inputs.
REQ-010 SHALL have LEDS  output  8  registered LED drive.

Function
REQ-011 SHALL decode: 0x20 SWITCHES (R), 0x24 {4'b0,BUTTONS} (R), 0x40 LEDS (R/W), 0x30 TMR_RELOAD (R/W), 0x31 TMR_PRESCALE (R/W), 0x32 TMR_CTRL (R/W; bit0 EN, bit1 IE, others read 0), 0x33 INT_STATUS (R; W1C bit0 PEND), 0x34 TMR_COUNT (R).
REQ-012 SHALL drive IN_PORT combinationally from PORT_ID over registered/synchronized sources (zero-cycle read latency, as MCU samples IN_PORT in the same execute cycle); unmapped IDs SHALL read 0x00.
REQ-013 SHALL commit a write on the rising edge where IO_STRB=1 and PORT_ID matches; writes to read-only or unmapped IDs SHALL be ignored; IO_STRB=0 SHALL never modify state.
REQ-014 SHALL present SWITCHES/BUTTONS through SYNC_STAGES flops; value visible on IN_PORT SYNC_STAGES cycles after input change.
REQ-015 Prescaler: 8-bit PSC counter; while EN=1, increments each cycle; when PSC==TMR_PRESCALE, PSC<=0 and one-cycle TICK asserted; PRESCALE=0 gives TICK every cycle.
REQ-016 On TICK: if TMR_COUNT==0 then TMR_COUNT<=TMR_RELOAD and PEND<=1, else TMR_COUNT<=TMR_COUNT-1; period = (RELOAD+1)*(PRESCALE+1) cycles.
REQ-017 EN=0 SHALL freeze PSC and TMR_COUNT; EN 0->1 resumes without reloading.
REQ-018 Write to 0x30 SHALL load TMR_RELOAD and TMR_COUNT and clear PSC in the same edge; this write wins over a coincident TICK.
REQ-019 INTR SHALL equal PEND & IE (registered sources, no combinational path from bus inputs).
REQ-020 Write to 0x33 with bit0=1 clears PEND; bit0=0 no effect; coincident expiry and clear SHALL leave PEND=1 (set wins).
REQ-021 Clearing IE SHALL drop INTR but retain PEND.

Reset
REQ-022 RESET_N=0 at a rising edge SHALL set LEDS, TMR_RELOAD, TMR_PRESCALE, TMR_CTRL, TMR_COUNT, PSC, PEND and synchronizer flops to 0; INTR=0 and IN_PORT reads 0x00 for all timer IDs the cycle after.
REQ-023 Reset SHALL override any coincident IO_STRB write or TICK; mid-count reset abandons the count.

Configuration
REQ-024 Macro RAT_IO_TIMER_EN defined: timer, prescaler and interrupt per REQ-015..021.
REQ-025 RAT_IO_TIMER_EN undefined: no timer logic instantiated, IDs 0x30-0x34 read 0x00 and ignore writes, INTR tied 0.

Structure
REQ-026 Shared package rat_io_pkg SHALL hold port-ID localparams, TMR_CTRL bit indices and INT_STATUS bit index.
REQ-027 Timer (PSC, TMR_COUNT, PEND) SHALL be sub-module rat_io_timer, instantiated only under RAT_IO_TIMER_EN.

Verification
REQ-028 Reset release, SWITCHES=0xA5, PORT_ID=0x20 -> IN_PORT=0x00 until 2 cycles after, then 0xA5; PORT_ID=0x55 -> 0x00.
REQ-029 IO_STRB=1, PORT_ID=0x40, OUT_PORT=0x3C -> LEDS=0x3C next cycle; same with IO_STRB=0 or PORT_ID=0x41 -> LEDS unchanged.
REQ-030 RELOAD=3, PRESCALE=1, CTRL=0x03 -> INTR rises exactly 8 cycles after CTRL write; write 0x01 to 0x33 -> INTR low next cycle, rises again 8 cycles later.
REQ-031 RELOAD=0, PRESCALE=0, CTRL=0x03, write 0x01 to 0x33 on expiry cycle -> PEND stays 1, INTR stays high.
REQ-032 Running timer, CTRL=0x01 -> INTR low with 0x33 reading 0x01 after expiry; RESET_N=0 mid-count -> TMR_COUNT, 0x33, LEDS read 0x00.
REQ-033 Build without RAT_IO_TIMER_EN, write 0xFF to 0x30-0x32 -> reads 0x00, INTR stays 0 for 1000 cycles.
